// File: rtl/alu_multicycle_exec.sv
// Execute-stage ALU: single-cycle logic/add/compare, iterative 1-bit-per-cycle shifts, valid/ready on both sides.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a combinational barrel shifter.
module alu_multicycle_exec #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  zero,
  output logic                  illegal
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1100;

`ifdef ALU_FAST_SHIFT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] res_q;
  logic                  zero_q;
  logic                  ill_q;
  logic [DATA_WIDTH-1:0] first_val;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SLL, OP_SRL, OP_SRA, OP_EQ, OP_SLT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] alu_eval(input logic [3:0]            op,
                                                     input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    logic signed [DATA_WIDTH-1:0] sa;
    logic signed [DATA_WIDTH-1:0] sb;
`ifdef ALU_FAST_SHIFT_EN
    logic [SHAMT_W-1:0] sh;
    sh = b[SHAMT_W-1:0];
`endif
    sa = a;
    sb = b;
    case (op)
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_ADD: return a + b;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL: return a << sh;
      OP_SRL: return a >> sh;
      OP_SRA: return sa >>> sh;
`else
      // Iterative build only reaches here for shamt==0, where the result is the operand itself.
      OP_SLL, OP_SRL, OP_SRA: return a;
`endif
      OP_EQ:  return {{(DATA_WIDTH-1){1'b0}}, (a == b)};
      OP_SLT: return {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
      default: return '0;
    endcase
  endfunction

`ifndef ALU_FAST_SHIFT_EN
  logic [3:0]            op_q;
  logic [DATA_WIDTH-1:0] sh_q;
  logic [DATA_WIDTH-1:0] sh_nxt;
  logic [SHAMT_W-1:0]    cnt_q;
  logic [SHAMT_W-1:0]    shamt;
  logic                  shift_start;

  function automatic logic [DATA_WIDTH-1:0] shift_one(input logic [3:0]            op,
                                                      input logic [DATA_WIDTH-1:0] v);
    case (op)
      OP_SLL:  return {v[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  return {1'b0, v[DATA_WIDTH-1:1]};
      default: return {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
    endcase
  endfunction

  assign shamt  = SrcB[SHAMT_W-1:0];
  assign sh_nxt = shift_one(op_q, sh_q);
`endif

  // The first bit is shifted during the accept cycle, so a shift of n bits reaches DONE n cycles after accept.
  always_comb begin
    first_val = alu_eval(Operation, SrcA, SrcB);
`ifndef ALU_FAST_SHIFT_EN
    shift_start = 1'b0;
    if (is_shift(Operation) && (shamt != '0)) begin
      first_val   = shift_one(Operation, SrcA);
      shift_start = (shamt > SHAMT_W'(1));
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifndef ALU_FAST_SHIFT_EN
            if (shift_start) state_nxt = SHIFT;
            else
`endif
            state_nxt = DONE;
          end
        end
`ifndef ALU_FAST_SHIFT_EN
        SHIFT: begin
          if (cnt_q == SHAMT_W'(1)) state_nxt = DONE;
        end
`endif
        DONE: begin
          if (out_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      zero_q <= 1'b0;
      ill_q  <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      op_q   <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
`endif
    end else if (flush) begin
`ifndef ALU_FAST_SHIFT_EN
      sh_q  <= '0;
      cnt_q <= '0;
`endif
    end else if ((state == IDLE) && in_valid) begin
`ifndef ALU_FAST_SHIFT_EN
      if (shift_start) begin
        op_q  <= Operation;
        sh_q  <= first_val;
        cnt_q <= shamt - SHAMT_W'(1);
      end else
`endif
      begin
        res_q  <= first_val;
        zero_q <= (first_val == '0);
        ill_q  <= !is_legal(Operation);
      end
    end
`ifndef ALU_FAST_SHIFT_EN
    else if (state == SHIFT) begin
      sh_q  <= sh_nxt;
      cnt_q <= cnt_q - SHAMT_W'(1);
      if (cnt_q == SHAMT_W'(1)) begin
        res_q  <= sh_nxt;
        zero_q <= (sh_nxt == '0);
        ill_q  <= 1'b0;
      end
    end
`endif
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign ALUResult = res_q;
  assign zero      = zero_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_multicycle_exec.sv
// Bench for alu_multicycle_exec: table-driven vectors through a scoreboard, plus backpressure, flush and reset sequences.
module tb_alu_multicycle_exec;
  localparam int W = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   Operation = '0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] ALUResult;
  logic         zero;
  logic         illegal;

  alu_multicycle_exec #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         il;
    int           lat;
  } vec_t;

  typedef struct {
    string        nm;
    logic [W-1:0] res;
    logic         z;
    logic         il;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[20];

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: compares the first cycle of each out_valid pulse against the oldest expectation.
  bit seen = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !out_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: out_valid high with nothing pending, ALUResult=0x%0h", ALUResult);
      end else begin
        e = sbq.pop_front();
        check({e.nm, "_result"}, ALUResult, e.res);
        check({e.nm, "_zero"}, W'(zero), W'(e.z));
        check({e.nm, "_illegal"}, W'(illegal), W'(e.il));
        check({e.nm, "_latency"}, W'(cyc - e.acc), W'(e.lat));
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input logic [W-1:0] r, input logic z, input logic il,
                       input int lat, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: in_ready=0, expected 1", nm);
      return;
    end
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    if (push) sbq.push_back('{nm, r, z, il, lat, cyc});
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    Operation = 4'($urandom);
    SrcA      = $urandom;
    SrcB      = $urandom;
  endtask

  task automatic drain(input string nm);
    int n;
    int busy;
    n = 0;
    busy = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
      if (sbq.size() != 0 && in_ready) busy++;
    end
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout: %0d results pending, expected 0", nm, sbq.size());
      sbq.delete();
    end
    checks++;
    check({nm, "_in_ready_busy"}, W'(busy), '0);
  endtask

  initial begin
    int bad_res, bad_v, bad_rdy, vcnt;

    vecs[0]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1};
    vecs[1]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1};
    vecs[2]  = '{OP_SRA, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0, 31};
    vecs[3]  = '{OP_SLL, 32'h00001234, 32'd0,        32'h00001234, 1'b0, 1'b0, 1};
    vecs[4]  = '{OP_SRL, 32'h000000F0, 32'd4,        32'h0000000F, 1'b0, 1'b0, 4};
    vecs[5]  = '{OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1};
    vecs[6]  = '{OP_EQ,  32'h00000005, 32'h00000005, 32'h00000001, 1'b0, 1'b0, 1};
    vecs[7]  = '{4'b1111, 32'h00000003, 32'h00000004, 32'h00000000, 1'b1, 1'b1, 1};
    vecs[8]  = '{OP_SRL, 32'h80000000, 32'd31,       32'h00000001, 1'b0, 1'b0, 31};
    vecs[9]  = '{OP_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 1};
    vecs[10] = '{OP_OR,  32'h00000F00, 32'h000000F0, 32'h00000FF0, 1'b0, 1'b0, 1};
    vecs[11] = '{OP_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1};
    vecs[12] = '{OP_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1};
    vecs[13] = '{OP_EQ,  32'h00000005, 32'h00000006, 32'h00000000, 1'b1, 1'b0, 1};
    vecs[14] = '{OP_SLL, 32'h00000001, 32'd1,        32'h00000002, 1'b0, 1'b0, 1};
    vecs[15] = '{4'b0011, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1'b1, 1'b1, 1};
    vecs[16] = '{OP_SRA, 32'h40000000, 32'd30,       32'h00000001, 1'b0, 1'b0, 30};
    vecs[17] = '{OP_SLL, 32'h00000003, 32'h00000124, 32'h00000030, 1'b0, 1'b0, 4};
    vecs[18] = '{OP_SRA, 32'hF0000000, 32'd4,        32'hFF000000, 1'b0, 1'b0, 4};
    vecs[19] = '{OP_SLL, 32'h80000001, 32'd2,        32'h00000004, 1'b0, 1'b0, 2};

    repeat (2) @(negedge clk);
    check("reset_out_valid", W'(out_valid), '0);
    check("reset_result", ALUResult, '0);
    check("reset_zero", W'(zero), '0);
    check("reset_illegal", W'(illegal), '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", W'(in_ready), W'(1));

    for (int i = 0; i < 20; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].res, vecs[i].z, vecs[i].il,
            vecs[i].lat, $sformatf("v%0d", i));
      drain($sformatf("v%0d", i));
    end

    // Backpressure: result must hold for 10 cycles with out_ready low.
    out_ready = 1'b0;
    issue(OP_OR, 32'h00FF00FF, 32'h0F000F00, 1'b1, 32'h0FFF0FFF, 1'b0, 1'b0, 1, "bp");
    bad_res = 0;
    bad_v = 0;
    bad_rdy = 0;
    repeat (10) begin
      @(negedge clk);
      if (ALUResult !== 32'h0FFF0FFF) bad_res++;
      if (out_valid !== 1'b1) bad_v++;
      if (in_ready !== 1'b0) bad_rdy++;
    end
    check("bp_result_unstable_cycles", W'(bad_res), '0);
    check("bp_out_valid_drop_cycles", W'(bad_v), '0);
    check("bp_in_ready_high_cycles", W'(bad_rdy), '0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", W'(in_ready), W'(1));
    check("bp_release_out_valid", W'(out_valid), '0);
    drain("bp");

    // Flush while idle drops the concurrent request.
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    Operation = OP_ADD;
    SrcA = 32'h1;
    SrcB = 32'h2;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_idle_out_valid", W'(out_valid), '0);
    check("flush_idle_in_ready", W'(in_ready), W'(1));

    // Flush in the third cycle of a 20-bit shift.
    issue(OP_SLL, 32'h00000001, 32'd20, 1'b0, '0, 1'b0, 1'b0, 0, "fl");
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    Operation = OP_ADD;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_shift_in_ready", W'(in_ready), W'(1));
    vcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    check("flush_shift_out_valid_cycles", W'(vcnt), '0);

    // Asynchronous reset in the middle of a shift.
    issue(OP_SRL, 32'h000000F0, 32'd4, 1'b1, 32'h0000000F, 1'b0, 1'b0, 4, "pre_rst");
    drain("pre_rst");
    issue(OP_SRA, 32'h80000000, 32'd20, 1'b0, '0, 1'b0, 1'b0, 0, "rst_shift");
    repeat (5) @(negedge clk);
    check("mid_shift_result_held", ALUResult, 32'h0000000F);
    check("mid_shift_in_ready", W'(in_ready), '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", W'(out_valid), '0);
    check("async_rst_result", ALUResult, '0);
    check("async_rst_zero", W'(zero), '0);
    check("async_rst_illegal", W'(illegal), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", W'(in_ready), W'(1));
    issue(OP_ADD, 32'd2, 32'd3, 1'b1, 32'd5, 1'b0, 1'b0, 1, "post_rst_add");
    drain("post_rst_add");
    issue(OP_SRL, 32'h00000100, 32'd3, 1'b1, 32'h00000020, 1'b0, 1'b0, 3, "post_rst_srl");
    drain("post_rst_srl");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_multicycle_exec.md
Name: alu_multicycle_exec

Overview:
- Execute-stage ALU that consumes the 4-bit Operation code produced by the ALU controller, together with two operands.
- Logical, add and compare ops complete in 1 cycle.
- Shifts run iteratively, 1 bit per cycle, to save area.
- Uses a valid/ready handshake on both sides so the pipeline can stall on long shifts; supports a pipeline flush.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be a power of 2, ≥ 8.
- SHAMT_W, $clog2(DATA_WIDTH), shift-amount width (local, derived).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous; abort any in-flight op
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept a request
- Operation  input  4  ALU op code (encoding below)
- SrcA  input  DATA_WIDTH  operand A
- SrcB  input  DATA_WIDTH  operand B; shifts use SrcB[SHAMT_W-1:0]
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- ALUResult  output  DATA_WIDTH  result
- zero  output  1  ALUResult == 0
- illegal  output  1  Operation was not a defined code

Behaviour:
- Encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (wraps mod 2^DATA_WIDTH, no carry out)
  - 0100 SLL
  - 0101 SRL
  - 0111 SRA
  - 1000 EQ (result 1 if SrcA==SrcB, else 0)
  - 1100 SLT (signed; result 1 or 0)
  - Any other code: result 0, illegal=1, latency 1.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). The request is accepted on the edge where in_valid && in_ready; operands and op are captured, so later input changes are ignored.
- IDLE on accept:
  - non-shift op, or shift with shamt==0: compute, register result → DONE.
  - shift with shamt>0: load SrcA into shift register, load count=shamt → SHIFT.
- SHIFT, each cycle:
  - shift register moves 1 bit (SLL: zero-fill LSB; SRL: zero-fill MSB; SRA: replicate MSB); count decrements.
  - the edge where count goes 1→0 → DONE.
- Latency from accept edge to out_valid: 1 cycle for all non-shift ops; max(1, shamt) cycles for shifts. Max latency is DATA_WIDTH-1.
- DONE:
  - out_valid=1; ALUResult, zero and illegal are held stable until out_ready.
  - on out_valid && out_ready → IDLE.
  - No new request is accepted in the same cycle; back-to-back throughput is 1 op per 2 cycles minimum.
- zero and illegal are registered with ALUResult and are only meaningful while out_valid=1.
- flush: in any state, at the next edge → IDLE; out_valid=0; any in_valid in that cycle is dropped; count and shift register are cleared. flush has priority over accept and over out_ready.
- Reset (rst_n low, async, any state including mid-shift):
  - state=IDLE; count=0; shift register=0.
  - ALUResult=0, zero=0, illegal=0, out_valid=0.
  - in_ready=1 once rst_n is released.
- out_ready low in DONE: hold indefinitely; no result is lost or altered.

Optional Feature:
- Macro: ALU_FAST_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter; the SHIFT state and count register are not generated; every op has latency 1 (IDLE→DONE).
- Undefined: iterative shifter as specified above.
- Handshake, flush and reset behaviour are identical in both builds.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, out_ready=1 → out_valid 1 cycle after accept, ALUResult=0x80000000, zero=0; ADD 0xFFFFFFFF+1 → 0, zero=1.
- SRA SrcA=0x80000000, SrcB=31 → out_valid exactly 31 cycles after accept, ALUResult=0xFFFFFFFF; in_ready low throughout.
- SLL shamt=0, SrcA=0x1234 → latency 1, result 0x1234; SRL SrcA=0xF0, shamt=4 → latency 4, result 0x0F.
- SLT SrcA=0xFFFFFFFF(-1), SrcB=1 → 1; EQ 5,5 → 1, zero=0; Operation=1111 → ALUResult=0, illegal=1.
- Backpressure: result ready with out_ready=0 for 10 cycles → ALUResult stable, in_ready=0; out_ready=1 → IDLE next edge, in_ready=1.
- Flush at cycle 3 of a 20-cycle SLL → IDLE next edge, out_valid never asserted. rst_n pulsed low mid-shift → all outputs 0 immediately (async); next op executes correctly.
